// File: rtl/scr1_dmem_arbiter.sv
// rtl/scr1_dmem_arbiter.sv - two-master SCR1 DMEM arbiter with round-robin or fixed-priority grant
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

`ifndef SCR1_MEMIF_PKG_DEFINED
`define SCR1_MEMIF_PKG_DEFINED
package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage
`endif

module scr1_dmem_arbiter
    import scr1_memif_pkg::*;
#(
    parameter logic SCR1_ARB_RR = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          m0_req,
    output logic                          m0_req_ack,
    input  type_scr1_mem_cmd_e            m0_cmd,
    input  type_scr1_mem_width_e          m0_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  m0_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  m0_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  m0_rdata,
    output type_scr1_mem_resp_e           m0_resp,

    input  logic                          m1_req,
    output logic                          m1_req_ack,
    input  type_scr1_mem_cmd_e            m1_cmd,
    input  type_scr1_mem_width_e          m1_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  m1_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  m1_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  m1_rdata,
    output type_scr1_mem_resp_e           m1_resp,

    output logic                          slv_req,
    input  logic                          slv_req_ack,
    output type_scr1_mem_cmd_e            slv_cmd,
    output type_scr1_mem_width_e          slv_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  slv_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  slv_wdata,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  slv_rdata,
    input  type_scr1_mem_resp_e           slv_resp
);

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } fsm_e;

    fsm_e fsm;
    logic owner_r;
    logic last_r;
    logic hold_vld_r;
    logic hold_sel_r;

    logic window_open;
    logic hold_eff;
    logic grant;
    logic grant_req;
    logic handshake;
    logic data_done;

    always_comb begin
        // A new address may overlap the completing data phase only on RDY_OK; RDY_ER closes the window.
        window_open = !rst && ((fsm == ST_ADDR) ||
                               ((fsm == ST_DATA) && (slv_resp == SCR1_MEM_RESP_RDY_OK)));
        // A held grant only sticks while its master still requests.
        hold_eff    = hold_vld_r && (hold_sel_r ? m1_req : m0_req);

        if (hold_eff) begin
            grant = hold_sel_r;
        end else if (m0_req ^ m1_req) begin
            grant = m1_req;
        end else if (m0_req && m1_req) begin
            grant = SCR1_ARB_RR ? ~last_r : 1'b0;
        end else begin
            grant = 1'b0;
        end

        grant_req  = grant ? m1_req : m0_req;
        slv_req    = window_open && grant_req;
        handshake  = slv_req && slv_req_ack;
        m0_req_ack = handshake && !grant;
        m1_req_ack = handshake && grant;

        slv_cmd    = grant ? m1_cmd   : m0_cmd;
        slv_width  = grant ? m1_width : m0_width;
        slv_addr   = grant ? m1_addr  : m0_addr;
        slv_wdata  = grant ? m1_wdata : m0_wdata;

        data_done  = (fsm == ST_DATA) &&
                     ((slv_resp == SCR1_MEM_RESP_RDY_OK) || (slv_resp == SCR1_MEM_RESP_RDY_ER));

        m0_resp    = (!rst && (fsm == ST_DATA) && !owner_r) ? slv_resp : SCR1_MEM_RESP_NOTRDY;
        m1_resp    = (!rst && (fsm == ST_DATA) &&  owner_r) ? slv_resp : SCR1_MEM_RESP_NOTRDY;
        m0_rdata   = owner_r ? '0 : slv_rdata;
        m1_rdata   = owner_r ? slv_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= ST_ADDR;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            hold_vld_r <= 1'b0;
            hold_sel_r <= 1'b0;
        end else if (handshake) begin
            fsm        <= ST_DATA;
            owner_r    <= grant;
            last_r     <= grant;
            hold_vld_r <= 1'b0;
        end else begin
            if (data_done) begin
                fsm <= ST_ADDR;
            end
            // Freeze the grant on an unacknowledged request so the slave sees a stable address.
            if (slv_req) begin
                hold_vld_r <= 1'b1;
                hold_sel_r <= grant;
            end else begin
                hold_vld_r <= hold_eff;
            end
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    a_ack_onehot : assert property (@(posedge clk) disable iff (rst)
        !(m0_req_ack && m1_req_ack));
    a_slv_known : assert property (@(posedge clk) disable iff (rst)
        slv_req |-> !$isunknown({slv_cmd, slv_width}));
`endif

endmodule

// File: tb/tb_scr1_dmem_arbiter.sv
// tb/tb_scr1_dmem_arbiter.sv - scoreboard bench for scr1_dmem_arbiter
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_dmem_arbiter;
    import scr1_memif_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                         m0_req, m1_req, slv_req_ack;
    type_scr1_mem_cmd_e           m0_cmd, m1_cmd;
    type_scr1_mem_width_e         m0_width, m1_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr, m1_addr;
    logic [`SCR1_DMEM_DWIDTH-1:0] m0_wdata, m1_wdata, slv_rdata;
    type_scr1_mem_resp_e          slv_resp;

    logic                         m0_req_ack, m1_req_ack, slv_req;
    logic [`SCR1_DMEM_DWIDTH-1:0] m0_rdata, m1_rdata, slv_wdata;
    type_scr1_mem_resp_e          m0_resp, m1_resp;
    type_scr1_mem_cmd_e           slv_cmd;
    type_scr1_mem_width_e         slv_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] slv_addr;

    logic                         b_m0_req_ack, b_m1_req_ack, b_slv_req;
    logic [`SCR1_DMEM_DWIDTH-1:0] b_m0_rdata, b_m1_rdata, b_slv_wdata;
    type_scr1_mem_resp_e          b_m0_resp, b_m1_resp;
    type_scr1_mem_cmd_e           b_slv_cmd;
    type_scr1_mem_width_e         b_slv_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] b_slv_addr;

    scr1_dmem_arbiter #(.SCR1_ARB_RR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .slv_req(slv_req), .slv_req_ack(slv_req_ack), .slv_cmd(slv_cmd), .slv_width(slv_width),
        .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_resp(slv_resp)
    );

    scr1_dmem_arbiter #(.SCR1_ARB_RR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_req_ack(b_m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata), .m0_resp(b_m0_resp),
        .m1_req(m1_req), .m1_req_ack(b_m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata), .m1_resp(b_m1_resp),
        .slv_req(b_slv_req), .slv_req_ack(slv_req_ack), .slv_cmd(b_slv_cmd), .slv_width(b_slv_width),
        .slv_addr(b_slv_addr), .slv_wdata(b_slv_wdata), .slv_rdata(slv_rdata), .slv_resp(slv_resp)
    );

    typedef struct {
        logic        m;
        logic [31:0] addr;
    } hs_t;

    typedef struct {
        logic                m;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
    } rs_t;

    hs_t qa[$];
    hs_t qb[$];
    rs_t qr[$];
    logic chk_b = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hs(input logic m, input logic [31:0] addr);
        hs_t h;
        h.m = m;
        h.addr = addr;
        qa.push_back(h);
    endtask

    task automatic push_rs(input logic m, input type_scr1_mem_resp_e resp, input logic [31:0] rdata);
        rs_t r;
        r.m = m;
        r.resp = resp;
        r.rdata = rdata;
        qr.push_back(r);
    endtask

    // Address-handshake monitor for the round-robin instance
    always @(negedge clk) begin : mon_hs
        hs_t h;
        if (slv_req && slv_req_ack) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL hs_unexpected: got ack m0=%b m1=%b addr=%h, required no handshake",
                         m0_req_ack, m1_req_ack, slv_addr);
            end else begin
                h = qa.pop_front();
                if ({m1_req_ack, m0_req_ack} !== (h.m ? 2'b10 : 2'b01) || slv_addr !== h.addr) begin
                    n_err++;
                    $display("FAIL hs_grant: got ack m1m0=%b addr=%h, required master %0d addr=%h",
                             {m1_req_ack, m0_req_ack}, slv_addr, h.m, h.addr);
                end
            end
        end
    end

    // Address-handshake monitor for the fixed-priority instance
    always @(negedge clk) begin : mon_hs_fixed
        hs_t h;
        if (chk_b && b_slv_req && slv_req_ack) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL fixed_hs_unexpected: got addr=%h, required no handshake", b_slv_addr);
            end else begin
                h = qb.pop_front();
                if ({b_m1_req_ack, b_m0_req_ack} !== (h.m ? 2'b10 : 2'b01) || b_slv_addr !== h.addr) begin
                    n_err++;
                    $display("FAIL fixed_hs_grant: got ack m1m0=%b addr=%h, required master %0d addr=%h",
                             {b_m1_req_ack, b_m0_req_ack}, b_slv_addr, h.m, h.addr);
                end
            end
        end
    end

    // Response monitor: any non-NOTRDY response to a master must be expected
    always @(negedge clk) begin : mon_rs
        rs_t r;
        logic act_m;
        type_scr1_mem_resp_e act_resp, other;
        logic [31:0] act_rd;
        if (m0_resp != SCR1_MEM_RESP_NOTRDY || m1_resp != SCR1_MEM_RESP_NOTRDY) begin
            n_vec++;
            if (qr.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got m0_resp=%0d m1_resp=%0d, required both NOTRDY",
                         m0_resp, m1_resp);
            end else begin
                r = qr.pop_front();
                act_m    = (m1_resp != SCR1_MEM_RESP_NOTRDY);
                act_resp = act_m ? m1_resp : m0_resp;
                other    = act_m ? m0_resp : m1_resp;
                act_rd   = act_m ? m1_rdata : m0_rdata;
                if (act_m !== r.m || act_resp !== r.resp || act_rd !== r.rdata ||
                    other !== SCR1_MEM_RESP_NOTRDY) begin
                    n_err++;
                    $display("FAIL resp: got master %0d resp=%0d rdata=%h other=%0d, required master %0d resp=%0d rdata=%h",
                             act_m, act_resp, act_rd, other, r.m, r.resp, r.rdata);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; slv_req_ack = 1'b0;
        m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_WR;
        m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
        m0_addr = '0; m1_addr = '0; m0_wdata = 32'h0000_00C0; m1_wdata = 32'h0000_00C1;
        slv_rdata = '0; slv_resp = SCR1_MEM_RESP_NOTRDY;
        tick(); tick();
        @(negedge clk);
        check("rst_slv_req", {31'd0, slv_req}, 32'd0);
        check("rst_acks", {30'd0, m1_req_ack, m0_req_ack}, 32'd0);
        check("rst_resps", {28'd0, m1_resp, m0_resp}, 32'd0);
        tick();
        rst = 1'b0;

        // Both masters request every cycle: RR alternates from M0, fixed always M0
        chk_b = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        slv_req_ack = 1'b1; slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h1234_5678;
        push_hs(1'b0, 32'h100); push_hs(1'b1, 32'h200); push_hs(1'b0, 32'h100); push_hs(1'b1, 32'h200);
        for (int i = 0; i < 4; i++) qb.push_back('{m: 1'b0, addr: 32'h100});
        push_rs(1'b0, SCR1_MEM_RESP_RDY_OK, 32'h1234_5678);
        push_rs(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h1234_5678);
        push_rs(1'b0, SCR1_MEM_RESP_RDY_OK, 32'h1234_5678);
        repeat (4) tick();
        chk_b = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        push_rs(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h1234_5678);
        tick();
        slv_resp = SCR1_MEM_RESP_NOTRDY;
        tick();

        // M1 stalled 3 cycles; M0 arrives in cycle 2 and must not steal the grant
        m1_req = 1'b1; m1_addr = 32'h0001_0004; slv_req_ack = 1'b0;
        m0_addr = 32'h0002_0008;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) m0_req = 1'b1;
            @(negedge clk);
            check($sformatf("hold_addr_c%0d", c), slv_addr, 32'h0001_0004);
            check($sformatf("hold_noack_c%0d", c), {30'd0, m1_req_ack, m0_req_ack}, 32'd0);
            tick();
        end
        slv_req_ack = 1'b1;
        push_hs(1'b1, 32'h0001_0004);
        @(negedge clk);
        check("hold_m1_ack", {31'd0, m1_req_ack}, 32'd1);
        tick();
        m1_req = 1'b0; slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h0000_00A5;
        push_rs(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h0000_00A5);
        push_hs(1'b0, 32'h0002_0008);
        tick();
        m0_req = 1'b0; slv_rdata = 32'h0000_00A6;
        push_rs(1'b0, SCR1_MEM_RESP_RDY_OK, 32'h0000_00A6);
        tick();
        slv_resp = SCR1_MEM_RESP_NOTRDY;
        tick();

        // M0 read with two NOTRDY wait cycles
        m0_req = 1'b1; m0_addr = 32'h0000_0300; slv_req_ack = 1'b1;
        push_hs(1'b0, 32'h300);
        tick();
        m0_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("wait_m0_resp_%0d", c), {30'd0, m0_resp}, 32'd0);
            check($sformatf("wait_m1_resp_%0d", c), {30'd0, m1_resp}, 32'd0);
            tick();
        end
        slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'hDEAD_BEEF;
        push_rs(1'b0, SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF);
        @(negedge clk);
        check("read_m1_resp", {30'd0, m1_resp}, 32'd0);
        tick();
        slv_resp = SCR1_MEM_RESP_NOTRDY;
        tick();

        // M1 data phase ends in RDY_ER while M0 waits: no grant that cycle
        m1_req = 1'b1; m1_addr = 32'h0000_0400;
        push_hs(1'b1, 32'h400);
        tick();
        m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h0000_0500;
        slv_resp = SCR1_MEM_RESP_RDY_ER; slv_rdata = 32'h0000_BAD0;
        push_rs(1'b1, SCR1_MEM_RESP_RDY_ER, 32'h0000_BAD0);
        @(negedge clk);
        check("er_no_slv_req", {31'd0, slv_req}, 32'd0);
        check("er_no_ack", {30'd0, m1_req_ack, m0_req_ack}, 32'd0);
        tick();
        slv_resp = SCR1_MEM_RESP_NOTRDY;
        push_hs(1'b0, 32'h500);
        @(negedge clk);
        check("er_m0_ack_next", {31'd0, m0_req_ack}, 32'd1);
        tick();
        m0_req = 1'b0;
        tick();

        // Reset during M0's data phase; the late RDY_OK must be ignored
        rst = 1'b1; m0_req = 1'b1; slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h0000_0077;
        @(negedge clk);
        check("midrst_slv_req", {31'd0, slv_req}, 32'd0);
        check("midrst_acks", {30'd0, m1_req_ack, m0_req_ack}, 32'd0);
        check("midrst_resps", {28'd0, m1_resp, m0_resp}, 32'd0);
        tick();
        rst = 1'b0; m1_req = 1'b1;
        push_hs(1'b0, 32'h500);
        @(negedge clk);
        check("postrst_resps", {28'd0, m1_resp, m0_resp}, 32'd0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        push_rs(1'b0, SCR1_MEM_RESP_RDY_OK, 32'h0000_0077);
        tick();
        slv_resp = SCR1_MEM_RESP_NOTRDY;
        repeat (3) tick();

        check("hs_queue_drained", qa.size(), 32'd0);
        check("fixed_queue_drained", qb.size(), 32'd0);
        check("resp_queue_drained", qr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
